// File: rtl/ar_fifo_pkg.sv
// Shared definitions for the SRL FIFO family: count sizing, threshold
// legality and the output-stage state encoding.
package ar_fifo_pkg;

    // Output register occupancy when the registered output stage is present.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    // COUNT must hold 0..DEPTH (+1 with the output register).
    function automatic int count_w(input int l2depth);
        return l2depth + 1;
    endfunction

    // Thresholds must be reachable for the flags to mean anything.
    function automatic bit thresh_ok(input int af, input int ae, input int cap);
        return (af <= cap) && (ae < cap) && (af >= 0) && (ae >= 0);
    endfunction

endpackage

// File: rtl/ar_srl_fifo_level_store.sv
// DEPTH x WIDTH shift array. New data enters at index 0 and everything moves
// up one slot; the oldest live entry is read at the given address.
module ar_srl_store #(
    parameter int WIDTH   = 8,
    parameter int L2DEPTH = 2
) (
    input  logic               CLK,
    input  logic               shift,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [L2DEPTH-1:0] addr,
    output logic [WIDTH-1:0]   d_out
);

    localparam int DEPTH = 1 << L2DEPTH;

    logic [WIDTH-1:0] dat [DEPTH];

    // Shift the whole array by one on each accepted write; contents are never reset.
    always_ff @(posedge CLK) begin
        if (shift) begin
            dat[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                dat[i] <= dat[i-1];
            end
        end
    end

    assign d_out = dat[addr];

endmodule

// File: rtl/ar_srl_fifo_level.sv
// SRL-based synchronous FIFO with fill level, almost-full/almost-empty flags,
// sticky overflow/underflow errors and an optional registered output stage.
module ar_srl_fifo_level
    import ar_fifo_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int L2DEPTH   = 5,
    parameter int OREG      = 0,
    parameter int AF_THRESH = (1 << L2DEPTH) - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLR,
    input  logic                 ENQ,
    input  logic                 DEQ,
    input  logic [WIDTH-1:0]     D_IN,
    output logic [WIDTH-1:0]     D_OUT,
    output logic                 FULL_N,
    output logic                 EMPTY_N,
    output logic [L2DEPTH:0]     COUNT,
    output logic                 ALMOST_FULL,
    output logic                 ALMOST_EMPTY,
    output logic                 OVF,
    output logic                 UNF
);

    localparam int DEPTH = 1 << L2DEPTH;
    localparam int CAP   = DEPTH + OREG;
    localparam int CW    = count_w(L2DEPTH);
    localparam logic [CW-1:0] CAP_C = CW'(CAP);

    if (!thresh_ok(AF_THRESH, AE_THRESH, CAP)) begin : g_bad_thresh
        $error("ar_srl_fifo_level: AF_THRESH/AE_THRESH out of range for capacity");
    end
    if (OREG != 0 && OREG != 1) begin : g_bad_oreg
        $error("ar_srl_fifo_level: OREG must be 0 or 1");
    end

    logic [CW-1:0]      count_q, count_nxt;
    logic [CW-1:0]      pos_q, pos_nxt;
    logic               full_n_q, empty_n_q, af_q, ae_q, ovf_q, unf_q;
    logic               acc_enq, acc_deq, shift;
    logic [L2DEPTH-1:0] rd_addr;
    logic [WIDTH-1:0]   srl_head;

    function automatic logic af_of(input logic [CW-1:0] c);
        return int'(c) >= AF_THRESH;
    endfunction

    function automatic logic ae_of(input logic [CW-1:0] c);
        return int'(c) <= AE_THRESH;
    endfunction

    // Acceptance depends only on registered flags, so no request reaches an output combinationally.
    assign acc_enq = ENQ & full_n_q;
    assign acc_deq = DEQ & empty_n_q;
    assign rd_addr = L2DEPTH'(pos_q - CW'(1));

    ar_srl_store #(
        .WIDTH   (WIDTH),
        .L2DEPTH (L2DEPTH)
    ) u_store (
        .CLK   (CLK),
        .shift (shift),
        .d_in  (D_IN),
        .addr  (rd_addr),
        .d_out (srl_head)
    );

    // Total occupancy after this edge; simultaneous accepts cancel out.
    always_comb begin
        count_nxt = count_q;
        if (acc_enq && !acc_deq) begin
            count_nxt = count_q + CW'(1);
        end else if (!acc_enq && acc_deq) begin
            count_nxt = count_q - CW'(1);
        end
    end

    if (OREG == 0) begin : g_direct
        // Without an output register the SRL holds everything and its head is the output.
        assign shift   = acc_enq;
        assign pos_nxt = count_nxt;
        assign D_OUT   = srl_head;
    end else begin : g_oreg
        out_state_t       state_q;
        logic [WIDTH-1:0] oreg_q;
        logic             srl_has;

        assign srl_has = (pos_q != '0);
        assign D_OUT   = oreg_q;

        // SRL only takes data once the output register is occupied and not being bypassed.
        always_comb begin
            shift   = 1'b0;
            pos_nxt = pos_q;
            if (state_q == OUT_VALID) begin
                if (acc_enq && !acc_deq) begin
                    shift   = 1'b1;
                    pos_nxt = pos_q + CW'(1);
                end else if (!acc_enq && acc_deq && srl_has) begin
                    pos_nxt = pos_q - CW'(1);
                end else if (acc_enq && acc_deq && srl_has) begin
                    shift = 1'b1;
                end
            end
        end

        // Output register FSM: load by bypass from D_IN or refill from the SRL head.
        always_ff @(posedge CLK) begin
            if (!RST_N || CLR) begin
                state_q <= OUT_EMPTY;
                oreg_q  <= '0;
            end else begin
                case (state_q)
                    OUT_EMPTY: begin
                        if (acc_enq) begin
                            oreg_q  <= D_IN;
                            state_q <= OUT_VALID;
                        end
                    end
                    OUT_VALID: begin
                        if (acc_deq) begin
                            if (srl_has) begin
                                oreg_q <= srl_head;
                            end else if (acc_enq) begin
                                oreg_q <= D_IN;
                            end else begin
                                state_q <= OUT_EMPTY;
                            end
                        end
                    end
                    default: state_q <= OUT_EMPTY;
                endcase
            end
        end
    end

    // Occupancy, flags and sticky errors; flags come from the next count so they track COUNT exactly.
    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            count_q   <= '0;
            pos_q     <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            af_q      <= af_of('0);
            ae_q      <= ae_of('0);
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            count_q   <= count_nxt;
            pos_q     <= pos_nxt;
            full_n_q  <= (count_nxt != CAP_C);
            empty_n_q <= (count_nxt != '0);
            af_q      <= af_of(count_nxt);
            ae_q      <= ae_of(count_nxt);
            ovf_q     <= ovf_q | (ENQ & ~full_n_q);
            unf_q     <= unf_q | (DEQ & ~empty_n_q);
        end
    end

    assign COUNT        = count_q;
    assign FULL_N       = full_n_q;
    assign EMPTY_N      = empty_n_q;
    assign ALMOST_FULL  = af_q;
    assign ALMOST_EMPTY = ae_q;
    assign OVF          = ovf_q;
    assign UNF          = unf_q;

endmodule

// File: tb/tb_ar_srl_fifo_level.sv
// Directed bench for ar_srl_fifo_level: one instance without and one with the
// registered output stage, WIDTH=8, L2DEPTH=2, AF_THRESH=3, AE_THRESH=1.
module tb_ar_srl_fifo_level;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: OREG=0 (capacity 4)
    logic       a_rst_n, a_clr, a_enq, a_deq;
    logic [7:0] a_din, a_dout;
    logic [2:0] a_count;
    logic       a_full_n, a_empty_n, a_af, a_ae, a_ovf, a_unf;

    // Instance B: OREG=1 (capacity 5)
    logic       b_rst_n, b_clr, b_enq, b_deq;
    logic [7:0] b_din, b_dout;
    logic [2:0] b_count;
    logic       b_full_n, b_empty_n, b_af, b_ae, b_ovf, b_unf;

    ar_srl_fifo_level #(
        .WIDTH(8), .L2DEPTH(2), .OREG(0), .AF_THRESH(3), .AE_THRESH(1)
    ) dut_a (
        .CLK(clk), .RST_N(a_rst_n), .CLR(a_clr), .ENQ(a_enq), .DEQ(a_deq),
        .D_IN(a_din), .D_OUT(a_dout), .FULL_N(a_full_n), .EMPTY_N(a_empty_n),
        .COUNT(a_count), .ALMOST_FULL(a_af), .ALMOST_EMPTY(a_ae),
        .OVF(a_ovf), .UNF(a_unf)
    );

    ar_srl_fifo_level #(
        .WIDTH(8), .L2DEPTH(2), .OREG(1), .AF_THRESH(3), .AE_THRESH(1)
    ) dut_b (
        .CLK(clk), .RST_N(b_rst_n), .CLR(b_clr), .ENQ(b_enq), .DEQ(b_deq),
        .D_IN(b_din), .D_OUT(b_dout), .FULL_N(b_full_n), .EMPTY_N(b_empty_n),
        .COUNT(b_count), .ALMOST_FULL(b_af), .ALMOST_EMPTY(b_ae),
        .OVF(b_ovf), .UNF(b_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] next_wr;
        a_rst_n = 1'b0; a_clr = 1'b0; a_enq = 1'b0; a_deq = 1'b0; a_din = '0;
        b_rst_n = 1'b0; b_clr = 1'b0; b_enq = 1'b0; b_deq = 1'b0; b_din = '0;
        tick(); tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();

        // Reset state, both instances
        check("a_rst_count",   a_count,   0);
        check("a_rst_empty_n", a_empty_n, 0);
        check("a_rst_full_n",  a_full_n,  1);
        check("a_rst_ae",      a_ae,      1);
        check("a_rst_af",      a_af,      0);
        check("a_rst_ovf",     a_ovf,     0);
        check("a_rst_unf",     a_unf,     0);
        check("b_rst_count",   b_count,   0);
        check("b_rst_dout",    b_dout,    0);
        check("b_rst_full_n",  b_full_n,  1);

        // A: fill with 0x11..0x44
        for (int i = 0; i < 4; i++) begin
            a_enq = 1'b1;
            a_din = 8'(8'h11 * (i + 1));
            tick();
            check("a_fill_count",  a_count,  i + 1);
            check("a_fill_af",     a_af,     (i + 1) >= 3);
            check("a_fill_ae",     a_ae,     (i + 1) <= 1);
            check("a_fill_full_n", a_full_n, (i + 1) != 4);
            check("a_fill_dout",   a_dout,   8'h11);
        end
        a_enq = 1'b0;

        // A: ENQ+DEQ while full -> dequeue only, OVF set
        a_enq = 1'b1; a_deq = 1'b1; a_din = 8'h55;
        tick();
        a_enq = 1'b0; a_deq = 1'b0;
        check("a_fulleq_count",  a_count,  3);
        check("a_fulleq_ovf",    a_ovf,    1);
        check("a_fulleq_full_n", a_full_n, 1);
        check("a_fulleq_af",     a_af,     1);
        check("a_fulleq_dout",   a_dout,   8'h22);

        // A: drain, 0x55 must never appear
        for (int i = 0; i < 3; i++) begin
            check("a_drain_dout", a_dout, 8'(8'h22 + 8'h11 * i));
            a_deq = 1'b1;
            tick();
        end
        a_deq = 1'b0;
        check("a_drain_empty_n", a_empty_n, 0);
        check("a_drain_count",   a_count,   0);

        // A: ENQ+DEQ while empty -> enqueue only, UNF set
        a_enq = 1'b1; a_deq = 1'b1; a_din = 8'h66;
        tick();
        a_enq = 1'b0; a_deq = 1'b0;
        check("a_emptyeq_count",   a_count,   1);
        check("a_emptyeq_dout",    a_dout,    8'h66);
        check("a_emptyeq_unf",     a_unf,     1);
        check("a_emptyeq_empty_n", a_empty_n, 1);
        check("a_emptyeq_ovf",     a_ovf,     1);
        a_deq = 1'b1;
        tick();
        a_deq = 1'b0;
        check("a_emptyeq_drain", a_count, 0);

        // A: CLR with ENQ at COUNT=2
        a_enq = 1'b1; a_din = 8'h01;
        tick();
        a_din = 8'h02;
        tick();
        check("a_clr_pre_count", a_count, 2);
        check("a_clr_pre_ae",    a_ae,    0);
        a_clr = 1'b1; a_din = 8'h03;
        tick();
        a_clr = 1'b0; a_enq = 1'b0;
        check("a_clr_count",   a_count,   0);
        check("a_clr_empty_n", a_empty_n, 0);
        check("a_clr_full_n",  a_full_n,  1);
        check("a_clr_ovf",     a_ovf,     0);
        check("a_clr_unf",     a_unf,     0);
        tick();
        check("a_clr_idle_count", a_count, 0);

        // B: fill with 0xA0..0xA4, capacity 5
        for (int i = 0; i < 5; i++) begin
            b_enq = 1'b1;
            b_din = 8'(8'hA0 + i);
            tick();
            check("b_fill_count",  b_count,  i + 1);
            check("b_fill_full_n", b_full_n, (i + 1) != 5);
            check("b_fill_af",     b_af,     (i + 1) >= 3);
            check("b_fill_dout",   b_dout,   8'hA0);
        end
        b_enq = 1'b0;

        // B: continuous dequeue with a producer that honours FULL_N
        next_wr = 8'hA5;
        for (int k = 0; k < 11; k++) begin
            check("b_stream_dout_pre", b_dout, 8'(8'hA0 + k));
            b_enq = b_full_n;
            b_din = next_wr;
            b_deq = 1'b1;
            tick();
            if (b_enq) next_wr = next_wr + 8'd1;
            check("b_stream_count", b_count, 4);
            check("b_stream_dout",  b_dout,  8'(8'hA1 + k));
        end
        b_enq = 1'b0; b_deq = 1'b0;
        check("b_stream_ovf", b_ovf, 0);

        // B: top up to full, then drain
        b_enq = 1'b1; b_din = 8'hAF;
        tick();
        b_enq = 1'b0;
        check("b_topup_count",  b_count,  5);
        check("b_topup_full_n", b_full_n, 0);
        for (int i = 0; i < 5; i++) begin
            check("b_drain_dout", b_dout, 8'(8'hAB + i));
            b_deq = 1'b1;
            tick();
            check("b_drain_empty_n", b_empty_n, i < 4);
        end
        b_deq = 1'b0;
        check("b_drain_count", b_count, 0);

        // B: bypass load, then ENQ+DEQ with an empty SRL
        b_enq = 1'b1; b_din = 8'h77;
        tick();
        check("b_byp_dout",  b_dout,  8'h77);
        check("b_byp_count", b_count, 1);
        b_deq = 1'b1; b_din = 8'h78;
        tick();
        b_enq = 1'b0;
        check("b_byp2_dout",  b_dout,  8'h78);
        check("b_byp2_count", b_count, 1);
        tick();
        b_deq = 1'b0;
        check("b_byp_empty_n", b_empty_n, 0);
        check("b_byp_unf",     b_unf,     0);
        b_deq = 1'b1;
        tick();
        b_deq = 1'b0;
        check("b_unf", b_unf, 1);
        check("b_unf_count", b_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
